// File: rtl/stream_dmux.sv
// stream_dmux: registered 1-to-CHANNELS stream demultiplexer.
//
// A single valid/ready input stream is routed to one output channel chosen by
// sel, or to every channel when bcast is set. Each channel owns a one-entry
// holding register, so a stalled consumer only blocks words aimed at it.
// A word accepted with an out-of-range sel is dropped and flagged on err.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   producer presents a word
//   in_ready   word can be accepted this cycle (combinational, independent of in_valid)
//   in_data    word to route
//   sel        target channel index
//   bcast      deliver to all channels, sel ignored
//   out_valid  bit i: channel i holds a word
//   out_ready  bit i: consumer i takes its word this cycle
//   out_data   channel i at [i*WIDTH +: WIDTH]
//   err        one-cycle pulse after an out-of-range word was accepted and discarded

module stream_dmux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err
);

  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic                err_q, err_d;

  logic [CHANNELS-1:0] sel_hit;
  logic                sel_ok;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] pop;
  logic                accept;

  // Decode sel against each real channel; sel values past CHANNELS-1 hit
  // nothing, which also gives the range check without out-of-bounds indexing.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
    end
    sel_ok = |sel_hit;
  end

  // A channel can take a word if it is empty or being drained this cycle.
  assign free = ~valid_q | out_ready;
  assign pop  = valid_q & out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      in_ready = 1'b0;
    end else if (bcast) begin
      // Broadcast is all-or-nothing: wait until every channel has room.
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & free);
    end else begin
      // Out-of-range words are always swallowed so the producer never stalls.
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load = bcast ? {CHANNELS{1'b1}} : sel_hit;
    end
    // Load wins over pop so a pop+load cycle keeps the channel full.
    valid_d = (valid_q & ~pop) | load;
    err_d   = accept & ~bcast & ~sel_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        // Data only changes on load; a plain pop leaves the last word visible.
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign out_valid = valid_q;
  assign err       = err_q;

endmodule
